// File: rtl/wb_isqrt_engine.sv
// Wishbone-slave integer square-root accelerator. Several operand/result channels
// share one iterative digit-by-digit root engine through a round-robin arbiter.
module wb_isqrt_engine #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CHANNELS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o,
    output logic        busy_o
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned RW = H + 2;
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned NW = $clog2(H + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_STORE} state_t;
    state_t state_q, state_d;

    logic [CHANNELS-1:0][WIDTH-1:0] op_q, op_d;
    logic [CHANNELS-1:0][H-1:0]     root_q, root_d;
    logic [CHANNELS-1:0][H:0]       rem_q, rem_d;
    logic [CHANNELS-1:0] done_q, done_d, pend_q, pend_d, ovr_q, ovr_d, en_q, en_d;
    logic [WIDTH-1:0] eop_q, eop_d;
    logic [H-1:0]     eroot_q, eroot_d;
    logic [RW-1:0]    erem_q, erem_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    g_q, g_d, last_q, last_d, grant_idx;
    logic             ack_q, ack_d, irq_q, irq_d;
    logic [31:0]      dat_q, dat_d, rdata, bmask;
    logic             grant_en, load_en, iter_en, store_en;

    logic          req, blk, ch_hit, is_op, is_root, is_rem, is_stat, is_en;
    logic [7:0]    off;
    logic [CW-1:0] ch_idx;
    logic [CHANNELS-1:0] insvc, busy_ch;
    logic [RW+1:0] ext, sub, diff;
    logic          unused_bits;

    assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign blk     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off     = wbs_adr_i[7:0];
    assign ch_idx  = off[4 +: CW];
    assign ch_hit  = (32'(off[7:4]) < CHANNELS);
    assign is_op   = ch_hit && (off[3:0] == 4'h0);
    assign is_root = ch_hit && (off[3:0] == 4'h4);
    assign is_rem  = ch_hit && (off[3:0] == 4'h8);
    assign is_stat = (off == 8'hF0);
    assign is_en   = (off == 8'hF4);
    assign bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign insvc   = (state_q != S_IDLE) ? (CHANNELS'(1) << g_q) : '0;
    assign busy_ch = pend_q | insvc;

    // One restoring step: trial subtract {root,01} from {rem,next two operand bits}.
    assign ext  = {erem_q, eop_q[WIDTH-1 -: 2]};
    assign sub  = {2'b00, eroot_q, 2'b01};
    assign diff = ext - sub;
    assign unused_bits = ^{diff[RW], erem_q[RW-1:H+1]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (|pend_q) state_d = S_LOAD;
            S_LOAD:  state_d = S_ITER;
            S_ITER:  if (cnt_q == NW'(H - 1)) state_d = S_STORE;
            S_STORE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_en = (state_q == S_IDLE) && (|pend_q);
        load_en  = (state_q == S_LOAD);
        iter_en  = (state_q == S_ITER);
        store_en = (state_q == S_STORE);
    end

    // Search starts one past the last grant so every pending channel gets a turn.
    always_comb begin
        int unsigned cand;
        logic        found;
        grant_idx = last_q;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = (32'(last_q) + i) % CHANNELS;
            if (!found && pend_q[CW'(cand)]) begin
                found     = 1'b1;
                grant_idx = CW'(cand);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (blk) begin
            if (is_op)   rdata = 32'(op_q[ch_idx]);
            if (is_root) rdata = 32'(root_q[ch_idx]);
            if (is_rem)  rdata = 32'(rem_q[ch_idx]);
            if (is_stat) begin
                rdata[CHANNELS-1:0]    = done_q;
                rdata[8 +: CHANNELS]   = pend_q;
                rdata[16 +: CHANNELS]  = ovr_q;
            end
            if (is_en)   rdata[CHANNELS-1:0] = en_q;
        end
    end

    always_comb begin
        op_d = op_q;  root_d = root_q;  rem_d = rem_q;
        done_d = done_q;  pend_d = pend_q;  ovr_d = ovr_q;  en_d = en_q;
        eop_d = eop_q;  eroot_d = eroot_q;  erem_d = erem_q;  cnt_d = cnt_q;
        g_d = g_q;  last_d = last_q;
        ack_d = req;
        dat_d = (req && !wbs_we_i) ? rdata : '0;
        irq_d = |(done_q & en_q);

        if (req && wbs_we_i && blk) begin
            if (is_op) begin
                if (busy_ch[ch_idx]) begin
                    ovr_d[ch_idx] = 1'b1;
                end else begin
                    op_d[ch_idx]   = WIDTH'((32'(op_q[ch_idx]) & ~bmask) | (wbs_dat_i & bmask));
                    pend_d[ch_idx] = 1'b1;
                    done_d[ch_idx] = 1'b0;
                end
            end
            if (is_stat && wbs_sel_i[0]) done_d = done_d & ~wbs_dat_i[CHANNELS-1:0];
            if (is_stat && wbs_sel_i[2]) ovr_d  = ovr_d & ~wbs_dat_i[16 +: CHANNELS];
            if (is_en && wbs_sel_i[0])   en_d   = wbs_dat_i[CHANNELS-1:0];
        end

        if (grant_en) begin
            g_d    = grant_idx;
            last_d = grant_idx;
        end
        if (load_en) begin
            eop_d       = op_q[g_q];
            erem_d      = '0;
            eroot_d     = '0;
            cnt_d       = '0;
            pend_d[g_q] = 1'b0;
        end
        if (iter_en) begin
            eop_d = eop_q << 2;
            cnt_d = cnt_q + NW'(1);
            if (!diff[RW+1]) begin
                erem_d  = diff[RW-1:0];
                eroot_d = {eroot_q[H-2:0], 1'b1};
            end else begin
                erem_d  = ext[RW-1:0];
                eroot_d = {eroot_q[H-2:0], 1'b0};
            end
        end
        // Placed after the W1C so a completion on the same edge survives the clear.
        if (store_en) begin
            root_d[g_q] = eroot_q;
            rem_d[g_q]  = erem_q[H:0];
            done_d[g_q] = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            op_q <= '0;  root_q <= '0;  rem_q <= '0;
            done_q <= '0;  pend_q <= '0;  ovr_q <= '0;  en_q <= '0;
            eop_q <= '0;  eroot_q <= '0;  erem_q <= '0;  cnt_q <= '0;
            g_q <= '0;  last_q <= CW'(CHANNELS - 1);
            ack_q <= 1'b0;  dat_q <= '0;  irq_q <= 1'b0;
        end else begin
            op_q <= op_d;  root_q <= root_d;  rem_q <= rem_d;
            done_q <= done_d;  pend_q <= pend_d;  ovr_q <= ovr_d;  en_q <= en_d;
            eop_q <= eop_d;  eroot_q <= eroot_d;  erem_q <= erem_d;  cnt_q <= cnt_d;
            g_q <= g_d;  last_q <= last_d;
            ack_q <= ack_d;  dat_q <= dat_d;  irq_q <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_isqrt_engine.sv
// Directed and random bench for wb_isqrt_engine: a queue holds the expected root/remainder
// of every accepted operand and is drained as channels report done.
module tb_wb_isqrt_engine;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack, irq, busy;
    logic [31:0] rdat;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        int unsigned ch;
        logic [31:0] op;
        logic [31:0] root;
        logic [31:0] rem;
    } exp_t;
    exp_t sb[$];

    wb_isqrt_engine #(.WIDTH(32), .CHANNELS(4), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .irq_o(irq), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] isqrt(input logic [31:0] x);
        longint lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return 32'(lo);
    endfunction

    task automatic push_exp(input int unsigned ch, input logic [31:0] op);
        exp_t e;
        e.ch   = ch;
        e.op   = op;
        e.root = isqrt(op);
        e.rem  = op - e.root * e.root;
        sb.push_back(e);
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE | 32'(off); dat = d; sel = s;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        if (!got) chk("write_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] d);
        logic got;
        got = 1'b0;
        d = '0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'(off); sel = 4'hF;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1'b1; d = rdat; end
        end
        if (!got) chk("read_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_done(input int unsigned ch);
        logic [31:0] st;
        logic        seen;
        seen = 1'b0;
        st = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            wb_read(8'hF0, st);
            if (st[ch]) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'(st[ch]), 32'd1);
    endtask

    // Pop the oldest expectation for this channel and compare the DUT result against it.
    task automatic finish_ch(input int unsigned ch);
        int          k;
        exp_t        e;
        logic [31:0] r, m;
        k = -1;
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].ch == ch) k = i;
        tests++;
        assert (k >= 0) else begin
            fails++;
            $error("FAIL sb_lookup: observed done on ch %0d expected no completion", ch);
        end
        if (k >= 0) begin
            e = sb[k];
            sb.delete(k);
            wb_read(8'(ch * 16 + 4), r);
            wb_read(8'(ch * 16 + 8), m);
            chk("root", r, e.root);
            chk("rem", m, e.rem);
            chk("invariant", r * r + m, e.op);
        end
        wb_write(8'hF0, 32'(1) << ch, 4'hF);
    endtask

    task automatic run(input int unsigned ch, input logic [31:0] op);
        push_exp(ch, op);
        wb_write(8'(ch * 16), op, 4'hF);
        wait_done(ch);
        finish_ch(ch);
    endtask

    initial begin
        logic [31:0] v;
        int unsigned n;
        int unsigned order[$];
        logic [3:0]  seen;
        logic [31:0] dir_ops[5] = '{32'h0, 32'h1, 32'h2, 32'h0001_0000, 32'h7FFF_FFFF};

        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
        rst_n = 1'b0;
        #23;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        wb_read(8'hF0, v);  chk("rst_status", v, 32'd0);
        wb_read(8'hF4, v);  chk("rst_irqen", v, 32'd0);
        wb_read(8'h04, v);  chk("rst_root0", v, 32'd0);
        wb_read(8'h3C, v);  chk("unmapped_3c", v, 32'd0);
        wb_read(8'h40, v);  chk("unmapped_ch4", v, 32'd0);
        wb_read(8'hF8, v);  chk("unmapped_f8", v, 32'd0);
        wb_write(8'hF4, 32'hFF, 4'hF);
        wb_read(8'hF4, v);  chk("irqen_mask", v, 32'h0F);

        // Full-scale operand, latency to irq measured from the write ack edge.
        wb_write(8'hF4, 32'h1, 4'hF);
        push_exp(0, 32'hFFFF_FFFF);
        wb_write(8'h00, 32'hFFFF_FFFF, 4'hF);
        n = 0;
        for (int i = 0; i < 40 && !irq; i++) begin
            @(posedge clk); #1;
            n++;
        end
        chk("irq_latency", n, 32'd20);
        wb_read(8'hF0, v);  chk("done0", v & 32'hFF, 32'h1);
        finish_ch(0);
        @(posedge clk); #1;
        chk("irq_cleared", 32'(irq), 32'd0);

        for (int i = 0; i < 5; i++) run(1, dir_ops[i]);

        // Round-robin order after writes to ch2, ch0, ch3.
        push_exp(2, 32'd1000);
        push_exp(0, 32'd144);
        push_exp(3, 32'hDEAD_BEEF);
        wb_write(8'h20, 32'd1000, 4'hF);
        wb_write(8'h00, 32'd144, 4'hF);
        wb_write(8'h30, 32'hDEAD_BEEF, 4'hF);
        wb_read(8'hF0, v);  chk("pending_after_grant", (v >> 8) & 32'hFF, 32'h09);
        seen = '0;
        for (int i = 0; i < 200 && seen != 4'b1101; i++) begin
            wb_read(8'hF0, v);
            for (int c = 0; c < 4; c++) begin
                if (v[c] && !seen[c]) begin
                    seen[c] = 1'b1;
                    order.push_back(c);
                end
            end
        end
        chk("order_count", order.size(), 32'd3);
        if (order.size() == 3) begin
            chk("order0", order[0], 32'd2);
            chk("order1", order[1], 32'd3);
            chk("order2", order[2], 32'd0);
        end
        finish_ch(2);
        finish_ch(3);
        finish_ch(0);

        // Second write while the channel is still busy must be dropped.
        push_exp(1, 32'h1234_5678);
        wb_write(8'h10, 32'h1234_5678, 4'hF);
        wb_write(8'h10, 32'h0000_FFFF, 4'hF);
        wb_read(8'hF0, v);  chk("overrun1", (v >> 16) & 32'hFF, 32'h02);
        wb_read(8'h10, v);  chk("operand_kept", v, 32'h1234_5678);
        wait_done(1);
        finish_ch(1);
        wb_write(8'hF0, 32'h0002_0000, 4'hF);
        wb_read(8'hF0, v);  chk("overrun_w1c", v, 32'd0);

        // Asynchronous reset in the middle of an iteration.
        wb_write(8'h00, 32'hFFFF_FFFF, 4'hF);
        repeat (8) @(posedge clk);
        #1;
        chk("busy_mid_iter", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("busy_async_rst", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("irq_after_abort", 32'(irq), 32'd0);
        wb_read(8'hF0, v);  chk("status_after_abort", v, 32'd0);
        wb_read(8'h04, v);  chk("root_after_abort", v, 32'd0);

        // Byte-lane write onto the reset operand value.
        push_exp(3, 32'h00BB_00DD);
        wb_write(8'h30, 32'hAABB_CCDD, 4'b0101);
        wb_read(8'h30, v);  chk("byte_lanes", v, 32'h00BB_00DD);
        wait_done(3);
        finish_ch(3);
        run(0, 32'd99);

        for (int i = 0; i < 1000; i++) run($urandom_range(3, 0), $urandom);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
